sample_tx: RTL and testbench

Serial audio transmitter at the output end of the synth effects chain. Accepts the 16-bit signed sample stream with its one-cycle `in_ready` strobe (the same stream format that echo and the other effects produce), buffers it in a small FIFO, and shifts it out MSB-first as an I2S-format frame. The mono sample is sent on both channels. The block generates its own bit clock and word-select, and reports FIFO overflow and underrun to the top level.

---
 rtl/sample_tx.sv | 113 +++++++++++
 tb/tb_sample_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_tx.sv
// sample_tx: I2S serial transmitter with a small FWFT sample FIFO, self-generated bclk/lrclk.
// Define SAMPLE_TX_UNDERRUN_ZERO_EN to transmit silence on underrun instead of repeating the last word.
module sample_tx #(
   parameter int BCLK_DIV = 4,
   parameter int FIFO_AW  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sample_in,
   input  logic        in_ready,
   input  logic        clr_flags,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata,
   output logic        overflow,
   output logic        underrun
);

   localparam int             DEPTH   = 1 << FIFO_AW;
   localparam logic [7:0]     DIV_TC  = 8'(BCLK_DIV - 1);
   localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);

   logic [7:0]       div_q;
   logic [4:0]       slot_q;
   logic [15:0]      w_q;
   logic [FIFO_AW:0] wptr_q, rptr_q;
   logic [15:0]      mem [DEPTH];

   logic             tick_fall, frame_start;
   logic             fifo_full, fifo_empty, push, pop, ovf_evt;
   logic [4:0]       slot_nxt;
   logic [3:0]       bit_idx;
   logic [15:0]      w_nxt;

   always_comb begin
      tick_fall   = (div_q == DIV_TC) && bclk;
      slot_nxt    = slot_q + 5'd1;
      frame_start = tick_fall && (slot_nxt == 5'd0);
      fifo_empty  = (wptr_q == rptr_q);
      fifo_full   = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
      pop         = frame_start && !fifo_empty;
      // a full FIFO still accepts a push in the cycle it is popped
      push        = in_ready && (!fifo_full || pop);
      ovf_evt     = in_ready && fifo_full && !pop;
      // slot 0 -> w[0], 1..16 -> w[16-s], 17..31 -> w[32-s]: all equal w[(-s) mod 16]
      bit_idx     = 4'd0 - slot_nxt[3:0];
      w_nxt       = w_q;
      if (pop)
         w_nxt = mem[rptr_q[FIFO_AW-1:0]];
      else if (frame_start) begin
`ifdef SAMPLE_TX_UNDERRUN_ZERO_EN
         w_nxt = 16'd0;
`else
         w_nxt = w_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q <= 8'd0;
         bclk  <= 1'b0;
      end else if (div_q == DIV_TC) begin
         div_q <= 8'd0;
         bclk  <= ~bclk;
      end else begin
         div_q <= div_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q   <= 5'd31;
         lrclk    <= 1'b0;
         sdata    <= 1'b0;
         w_q      <= 16'd0;
         underrun <= 1'b0;
      end else begin
         underrun <= frame_start && fifo_empty;
         if (tick_fall) begin
            slot_q <= slot_nxt;
            lrclk  <= slot_nxt[4];
            sdata  <= w_q[bit_idx];
            w_q    <= w_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_ONE;
         if (pop)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q[FIFO_AW-1:0]] <= sample_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overflow <= 1'b0;
      else if (ovf_evt)
         overflow <= 1'b1;
      else if (clr_flags)
         overflow <= 1'b0;
   end

endmodule

// File: tb/tb_sample_tx.sv
// tb_sample_tx: randomized and directed checks of sample_tx against a frame-level reference model.
module tb_sample_tx;
   localparam int D     = 4;
   localparam int TP    = 2 * D;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] sample_in = 16'd0;
   logic        in_ready = 1'b0;
   logic        clr_flags = 1'b0;
   logic        bclk, lrclk, sdata, overflow, underrun;

   int tests = 0;
   int fails = 0;

   // reference model state; t counts cycles since reset release
   int          t;
   logic [15:0] q[$];
   logic [15:0] m_w;
   logic        m_ovf, m_und, m_sd, m_lr;

   sample_tx #(.BCLK_DIV(D), .FIFO_AW(2)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .in_ready(in_ready),
      .clr_flags(clr_flags), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
      .overflow(overflow), .underrun(underrun)
   );

   always #5 clk = ~clk;

   function automatic int slot_of(input int tt);
      return (tt / TP - 1) % 32;
   endfunction

   function automatic logic m_bc();
      return logic'((t / D) % 2);
   endfunction

   task automatic model_reset();
      t = 0; q.delete(); m_w = 16'd0;
      m_ovf = 0; m_und = 0; m_sd = 0; m_lr = 0;
   endtask

   task automatic model_edge(input logic ir, input logic [15:0] d, input logic clr);
      int n, s;
      logic [15:0] wold;
      logic evt;
      n = t + 1;
      m_und = 0;
      if (n % TP == 0) begin
         s = slot_of(n);
         m_lr = (s >= 16);
         wold = m_w;
         if (s == 0) begin
            m_sd = wold[0];
            if (q.size() > 0) m_w = q.pop_front();
            else begin
               m_und = 1;
`ifdef SAMPLE_TX_UNDERRUN_ZERO_EN
               m_w = 16'd0;
`endif
            end
         end else if (s <= 16) m_sd = m_w[16-s];
         else m_sd = m_w[32-s];
      end
      evt = 0;
      if (ir) begin
         if (q.size() < DEPTH) q.push_back(d);
         else evt = 1;
      end
      if (evt) m_ovf = 1;
      else if (clr) m_ovf = 0;
      t = n;
   endtask

   // called at a negedge; returns at the next negedge with the model advanced one cycle
   task automatic step(input logic ir, input logic [15:0] d, input logic clr);
      in_ready = ir; sample_in = d; clr_flags = clr;
      @(posedge clk);
      model_edge(ir, d, clr);
      @(negedge clk);
      in_ready = 0; clr_flags = 0;
   endtask

   task automatic test_reset();
      int fall_t;
      logic pb;
      reset = 0;
      model_reset();
      repeat (10) @(negedge clk);
      tests++;
      if ({bclk, lrclk, sdata, overflow, underrun} !== 5'b0) begin
         fails++; $display("FAIL reset_outputs got=%b want=00000", {bclk, lrclk, sdata, overflow, underrun});
      end
      reset = 1;
      fall_t = -1; pb = bclk;
      for (int i = 0; i < 12; i++) begin
         step(0, 16'd0, 0);
         if (pb && !bclk && fall_t < 0) begin
            fall_t = t;
            tests++;
            if (underrun !== 1'b1) begin
               fails++; $display("FAIL first_tick_underrun got=%b want=1", underrun);
            end
         end
         pb = bclk;
      end
      tests++;
      if (fall_t != TP) begin
         fails++; $display("FAIL first_fall_cycle got=%0d want=%0d", fall_t, TP);
      end
   endtask

   task automatic test_single_sample();
      logic [31:0] cap;
      int got, lr_bad, s;
      logic seen0;
      got = 0; lr_bad = 0; seen0 = 0; cap = '0;
      step(1, 16'hA5C3, 0);
      for (int i = 0; i < 1200 && got < 32; i++) begin
         step(0, 16'd0, 0);
         if (t % TP == 0) begin
            s = slot_of(t);
            if (seen0) begin
               cap = {cap[30:0], sdata}; got++;
            end
            if (seen0 || s == 0) begin
               if (lrclk !== logic'(s >= 16)) lr_bad++;
            end
            if (s == 0) seen0 = 1;
         end
      end
      tests++;
      if (cap !== 32'hA5C3A5C3) begin
         fails++; $display("FAIL single_frame_bits got=%h want=a5c3a5c3", cap);
      end
      tests++;
      if (lr_bad != 0) begin
         fails++; $display("FAIL single_frame_lrclk bad_slots=%0d want=0", lr_bad);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] v[5];
      logic [15:0] lch, exp_w;
      int k, s, und_bad;
      for (int i = 0; i < 5; i++) v[i] = 16'($urandom);
      v[4] = v[3] ^ 16'h8001;
      for (int i = 0; i < 5; i++) step(1, v[i], 0);
      tests++;
      if (overflow !== 1'b1) begin
         fails++; $display("FAIL overflow_set got=%b want=1", overflow);
      end
      step(0, 16'd0, 1);
      tests++;
      if (overflow !== 1'b0) begin
         fails++; $display("FAIL overflow_clear got=%b want=0", overflow);
      end
      k = -1; und_bad = 0; lch = '0;
      for (int i = 0; i < 6 * 64 * D; i++) begin
         step(0, 16'd0, 0);
         if (t % TP != 0) begin
            if (underrun) und_bad++;
         end else begin
            s = slot_of(t);
            if (s == 0) begin
               k++;
               tests++;
               if (underrun !== logic'(k == 4)) begin
                  fails++; $display("FAIL underrun_frame%0d got=%b want=%b", k, underrun, k == 4);
               end
            end
            if (k >= 0 && s >= 1 && s <= 16) lch = {lch[14:0], sdata};
            if (k >= 0 && s == 16) begin
`ifdef SAMPLE_TX_UNDERRUN_ZERO_EN
               exp_w = (k == 4) ? 16'd0 : v[k];
`else
               exp_w = (k == 4) ? v[3] : v[k];
`endif
               tests++;
               if (lch !== exp_w) begin
                  fails++; $display("FAIL ovf_frame%0d_data got=%h want=%h", k, lch, exp_w);
               end
               if (k == 4) break;
            end
         end
      end
      tests++;
      if (und_bad != 0 || k != 4) begin
         fails++; $display("FAIL underrun_pulse stray=%0d frames=%0d want=0/4", und_bad, k);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < DEPTH; i++) step(1, 16'($urandom), 0);
      for (int i = 0; i < 700; i++) begin
         if ((t + 1) % TP == 0 && slot_of(t + 1) == 0) break;
         step(0, 16'd0, 0);
      end
      step(1, 16'h1234, 0);
      tests++;
      if (overflow !== 1'b0 || underrun !== 1'b0) begin
         fails++; $display("FAIL push_on_pop ovf=%b und=%b want=0/0", overflow, underrun);
      end
      step(1, 16'h5678, 0);
      tests++;
      if (overflow !== 1'b1) begin
         fails++; $display("FAIL still_full got=%b want=1", overflow);
      end
      step(0, 16'd0, 1);
      step(1, 16'h9abc, 1);
      tests++;
      if (overflow !== 1'b1) begin
         fails++; $display("FAIL clr_vs_event got=%b want=1", overflow);
      end
      step(0, 16'd0, 1);
   endtask

   task automatic test_random();
      logic [4:0] got, want;
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 179) == 0, 16'($urandom), $urandom_range(0, 499) == 0);
         got  = {bclk, lrclk, sdata, overflow, underrun};
         want = {m_bc(), m_lr, m_sd, m_ovf, m_und};
         tests++;
         if (got !== want) begin
            fails++; $display("FAIL random_t%0d got=%b want=%b", t, got, want);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [4:0] got, want;
      for (int i = 0; i < 300; i++) begin
         step(0, 16'd0, 0);
         if (t % TP == 0 && slot_of(t) == 20) break;
      end
      step(1, 16'h0f0f, 0);
      step(1, 16'hf0f0, 0);
      #1 reset = 0;
      #1;
      tests++;
      if ({bclk, lrclk, sdata, overflow, underrun} !== 5'b0) begin
         fails++; $display("FAIL midreset_async got=%b want=00000", {bclk, lrclk, sdata, overflow, underrun});
      end
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1;
      for (int i = 0; i < 300; i++) begin
         step(0, 16'd0, 0);
         got  = {bclk, lrclk, sdata, overflow, underrun};
         want = {m_bc(), m_lr, m_sd, m_ovf, m_und};
         tests++;
         if (got !== want) begin
            fails++; $display("FAIL midreset_t%0d got=%b want=%b", t, got, want);
         end
         if (t == TP) begin
            tests++;
            if (underrun !== 1'b1 || bclk !== 1'b0) begin
               fails++; $display("FAIL midreset_restart und=%b bclk=%b want=1/0", underrun, bclk);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_sample();
      test_overflow();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
